// File: rtl/fecg_pkg.sv
// Shared types and helpers for the ECG window buffer: bank state encoding,
// default sample width and the sample-to-integer sign extension.
package fecg_pkg;

    localparam int DEFAULT_DATA_W = 16;

    typedef enum logic [1:0] {
        BANK_EMPTY   = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2
    } bank_state_e;

    // Sign-extends the low 'width' bits of raw to a 32-bit integer.
    function automatic logic signed [31:0] sign_extend(input logic [31:0] raw,
                                                       input int unsigned width);
        logic signed [31:0] shifted;
        shifted = raw << (32 - width);
        return shifted >>> (32 - width);
    endfunction

endpackage

// File: rtl/fecg_window_bank.sv
// One SIZE_A x SIZE_B window bank: column-write storage plus its
// EMPTY/FILLING/FULL state register.
module fecg_window_bank
    import fecg_pkg::*;
#(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int COL_W  = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en_i,
    input  logic [COL_W-1:0]   wr_col_i,
    input  logic               wr_last_i,
    input  logic signed [31:0] wr_data_i [SIZE_A],
    input  logic               clear_i,
    input  logic               consume_i,
    output bank_state_e        state_o,
    output logic signed [31:0] data_o [SIZE_A][SIZE_B]
);

    bank_state_e        state_q, state_d;
    logic signed [31:0] mem_q [SIZE_A][SIZE_B];

    // Consume and write never target the same bank: a FULL bank is never written.
    always_comb begin
        state_d = state_q;
        if (consume_i) begin
            state_d = BANK_EMPTY;
        end
        if (wr_en_i) begin
            state_d = wr_last_i ? BANK_FULL : BANK_FILLING;
        end else if (clear_i && state_q == BANK_FILLING) begin
            state_d = BANK_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BANK_EMPTY;
            for (int i = 0; i < SIZE_A; i++) begin
                for (int j = 0; j < SIZE_B; j++) begin
                    mem_q[i][j] <= '0;
                end
            end
        end else begin
            state_q <= state_d;
            if (wr_en_i) begin
                for (int i = 0; i < SIZE_A; i++) begin
                    mem_q[i][wr_col_i] <= wr_data_i[i];
                end
            end
        end
    end

    assign state_o = state_q;
    assign data_o  = mem_q;

endmodule

// File: rtl/ecg_window_buffer.sv
// Ping-pong window buffer: assembles ECG sample vectors column by column into
// SIZE_A x SIZE_B integer windows and hands them to the norm stage.
module ecg_window_buffer
    import fecg_pkg::*;
#(
    parameter int SIZE_A = 8,
    parameter int SIZE_B = 8,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_sample [SIZE_A],
    input  logic                     flush,
    output logic                     mat_valid,
    input  logic                     mat_ready,
    output logic signed [31:0]       mat_out [SIZE_A][SIZE_B],
    output bank_state_e              dbg_bank_state [2]
);

    localparam int COL_W = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SIZE_B - 1);

    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               accept, do_write, consume, last_col;
    logic signed [31:0] wr_data [SIZE_A];
    bank_state_e        bank_state [2];
    logic signed [31:0] bank_data [2][SIZE_A][SIZE_B];

    // Handshakes: a beat moves on in_valid && in_ready, a window on
    // mat_valid && mat_ready; both ready/valid outputs depend only on registers.
    assign in_ready  = (bank_state[wr_q] != BANK_FULL);
    assign mat_valid = (bank_state[rd_q] == BANK_FULL);
    assign mat_out   = bank_data[rd_q];

    assign accept   = in_valid && in_ready;
    assign do_write = accept && !flush;
    assign consume  = mat_valid && mat_ready;
    assign last_col = (col_q == LAST_COL);

    always_comb begin
        for (int i = 0; i < SIZE_A; i++) begin
            wr_data[i] = sign_extend(32'(in_sample[i]), DATA_W);
        end
    end

    always_comb begin
        col_d = col_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (flush) begin
            col_d = '0;
        end else if (do_write) begin
            if (last_col) begin
                col_d = '0;
                wr_d  = ~wr_q;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
        if (consume) begin
            rd_d = ~rd_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= 1'b0;
            rd_q  <= 1'b0;
            col_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            col_q <= col_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fecg_window_bank #(
            .SIZE_A (SIZE_A),
            .SIZE_B (SIZE_B),
            .COL_W  (COL_W)
        ) u_bank (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (do_write && (wr_q == 1'(b))),
            .wr_col_i  (col_q),
            .wr_last_i (last_col),
            .wr_data_i (wr_data),
            .clear_i   (flush && (wr_q == 1'(b))),
            .consume_i (consume && (rd_q == 1'(b))),
            .state_o   (bank_state[b]),
            .data_o    (bank_data[b])
        );
    end

    assign dbg_bank_state = bank_state;

endmodule

// File: tb/tb_ecg_window_buffer.sv
// Randomized and directed bench for ecg_window_buffer (SIZE_A=2, SIZE_B=3)
// against a window-queue reference model.
module tb_ecg_window_buffer;
  import fecg_pkg::*;

  localparam int SA = 2;
  localparam int SB = 3;
  localparam int DW = 16;

  typedef logic signed [31:0] vec_t [SA];
  typedef logic signed [31:0] win_t [SA][SB];

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_sample [SA];
  logic                 flush;
  logic                 mat_valid;
  logic                 mat_ready;
  logic signed [31:0]   mat_out [SA][SB];
  bank_state_e          dbg_bank_state [2];

  ecg_window_buffer #(.SIZE_A(SA), .SIZE_B(SB), .DATA_W(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sample      (in_sample),
    .flush          (flush),
    .mat_valid      (mat_valid),
    .mat_ready      (mat_ready),
    .mat_out        (mat_out),
    .dbg_bank_state (dbg_bank_state)
  );

  // ---------------- scoreboard ----------------
  win_t exp_q[$];   // complete windows waiting for downstream, oldest first
  vec_t part_q[$];  // beats of the window being assembled
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    check_val("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
    check_val("mat_valid", {31'b0, mat_valid}, {31'b0, exp_q.size() > 0});
    if (exp_q.size() > 0) begin
      for (int r = 0; r < SA; r++) begin
        for (int c = 0; c < SB; c++) begin
          check_val($sformatf("mat_out[%0d][%0d]", r, c), mat_out[r][c], exp_q[0][r][c]);
        end
      end
    end
  endtask

  // One clock: update the model from the inputs seen at the edge, then check.
  task automatic tick();
    bit   acc;
    bit   cons;
    vec_t v;
    win_t w;
    @(posedge clk);
    acc  = in_valid && (exp_q.size() < 2);
    cons = mat_ready && (exp_q.size() > 0);
    if (cons) void'(exp_q.pop_front());
    if (flush) begin
      part_q.delete();
    end else if (acc) begin
      for (int i = 0; i < SA; i++) v[i] = 32'(in_sample[i]);
      part_q.push_back(v);
      if (part_q.size() == SB) begin
        for (int c = 0; c < SB; c++)
          for (int r = 0; r < SA; r++) w[r][c] = part_q[c][r];
        exp_q.push_back(w);
        part_q.delete();
      end
    end
    #1;
    check_outputs();
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input int a, input int b, input bit fl, input bit mr);
    in_valid     = v;
    in_sample[0] = DW'(a);
    in_sample[1] = DW'(b);
    flush        = fl;
    mat_ready    = mr;
  endtask

  task automatic beat(input int a, input int b);
    drive(1'b1, a, b, 1'b0, 1'b0);
    tick();
  endtask

  task automatic drain();
    drive(1'b0, 0, 0, 1'b0, 1'b1);
    repeat (3) tick();
    drive(1'b0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_state(input string tag);
    check_val({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    check_val({tag, "_mat_valid"}, {31'b0, mat_valid}, 32'd0);
    for (int r = 0; r < SA; r++)
      for (int c = 0; c < SB; c++)
        check_val($sformatf("%s_mat[%0d][%0d]", tag, r, c), mat_out[r][c], 32'd0);
    for (int b = 0; b < 2; b++)
      check_val($sformatf("%s_bank%0d", tag, b), {30'b0, dbg_bank_state[b]}, {30'b0, BANK_EMPTY});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    #12;
    check_reset_state("reset");
    @(negedge clk);
    rst = 1'b0;

    // Single window
    beat(1, -1);
    beat(2, -2);
    beat(3, -3);
    check_val("single_r0c2", mat_out[0][2], 32'd3);
    check_val("single_r1c0", mat_out[1][0], 32'hFFFF_FFFF);

    // Backpressure: second window fills, further beats stall
    beat(4, -4);
    beat(5, -5);
    beat(6, -6);
    check_val("bp_ready_low", {31'b0, in_ready}, 32'd0);
    for (int k = 7; k <= 9; k++) begin
      drive(1'b1, k, -k, 1'b0, 1'b0);
      repeat (2) tick();
    end
    check_val("bp_hold_r0c0", mat_out[0][0], 32'd1);
    drain();

    // Final-column accept coincides with a consume
    beat(11, 21);
    beat(12, 22);
    beat(13, 23);
    beat(14, 24);
    beat(15, 25);
    drive(1'b1, 16, 26, 1'b0, 1'b1);
    tick();
    check_val("simul_ready", {31'b0, in_ready}, 32'd1);
    check_val("simul_r0c0", mat_out[0][0], 32'd14);
    drain();

    // Flush together with a beat
    beat(5, 5);
    beat(6, 6);
    drive(1'b1, 7, 7, 1'b1, 1'b0);
    tick();
    beat(8, 8);
    beat(9, 9);
    beat(10, 10);
    check_val("flush_r0c0", mat_out[0][0], 32'd8);
    check_val("flush_r1c2", mat_out[1][2], 32'd10);
    drain();

    // Sign extension of the most negative sample
    beat(-32768, 32767);
    beat(-32768, 32767);
    beat(-32768, 32767);
    check_val("sext_neg", mat_out[0][0], 32'hFFFF_8000);
    check_val("sext_pos", mat_out[1][1], 32'h0000_7FFF);
    drain();

    // Reset mid-operation with one window FULL
    beat(31, 41);
    beat(32, 42);
    beat(33, 43);
    beat(34, 44);
    beat(35, 45);
    #2;
    rst = 1'b1;
    drive(1'b0, 0, 0, 1'b0, 1'b0);
    exp_q.delete();
    part_q.delete();
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    beat(51, -51);
    beat(52, -52);
    beat(53, -53);
    check_val("postrst_r1c2", mat_out[1][2], 32'(-53));
    drain();

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      drive($urandom_range(0, 3) != 0, int'($urandom_range(0, 65535)) - 32768,
            int'($urandom_range(0, 65535)) - 32768,
            $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
